dsp48a1_slice: RTL and testbench



---
 rtl/dsp48a1_pkg.sv | 23 ++
 rtl/dsp48a1_slice_if.sv | 36 +++
 rtl/dsp48a1_pipe_reg.sv | 30 +++
 rtl/dsp48a1_slice.sv | 121 ++++++++++++
 tb/tb_dsp48a1_slice.sv | 136 +++++++++++++
 5 files changed

// File: rtl/dsp48a1_pkg.sv
// Shared widths, OPMODE field positions, mux encodings and source-select names for the DSP48A1 slice.
package dsp48a1_pkg;

   localparam int W_AB = 18;
   localparam int W_M  = 36;
   localparam int W_P  = 48;

   localparam int OP_X_LSB    = 0;
   localparam int OP_Z_LSB    = 2;
   localparam int OP_PRE_EN   = 4;
   localparam int OP_CIN      = 5;
   localparam int OP_PRE_SUB  = 6;
   localparam int OP_POST_SUB = 7;

   typedef enum logic [1:0] {X_ZERO = 2'd0, X_M = 2'd1, X_P = 2'd2, X_CAT = 2'd3} x_sel_e;
   typedef enum logic [1:0] {Z_ZERO = 2'd0, Z_PCIN = 2'd1, Z_P = 2'd2, Z_C = 2'd3} z_sel_e;

   localparam string CINSEL_OPMODE5 = "OPMODE5";
   localparam string CINSEL_CARRYIN = "CARRYIN";
   localparam string BIN_DIRECT     = "DIRECT";
   localparam string BIN_CASCADE    = "CASCADE";

endpackage

// File: rtl/dsp48a1_slice_if.sv
// Data, control and cascade bundle of the DSP48A1 slice; PZERO exists only with DSP48A1_ZERO_DETECT_EN.
interface dsp48a1_slice_if;
   import dsp48a1_pkg::*;

   logic [W_AB-1:0] A, B, D, BCIN, BCOUT;
   logic [W_P-1:0]  C, PCIN, P, PCOUT;
   logic [W_M-1:0]  M;
   logic [7:0]      OPMODE;
   logic            CARRYIN, CARRYOUT, CARRYOUTF;
   logic            CEA, CEB, CEC, CED, CEM, CEP, CECARRYIN, CEOPMODE;
   logic            RSTA, RSTB, RSTC, RSTD, RSTM, RSTP, RSTCARRYIN, RSTOPMODE;
`ifdef DSP48A1_ZERO_DETECT_EN
   logic            PZERO;
`endif

   modport master (
      output A, B, D, C, BCIN, PCIN, OPMODE, CARRYIN,
      output CEA, CEB, CEC, CED, CEM, CEP, CECARRYIN, CEOPMODE,
      output RSTA, RSTB, RSTC, RSTD, RSTM, RSTP, RSTCARRYIN, RSTOPMODE,
`ifdef DSP48A1_ZERO_DETECT_EN
      input  PZERO,
`endif
      input  M, P, PCOUT, CARRYOUT, CARRYOUTF, BCOUT
   );

   modport slave (
      input  A, B, D, C, BCIN, PCIN, OPMODE, CARRYIN,
      input  CEA, CEB, CEC, CED, CEM, CEP, CECARRYIN, CEOPMODE,
      input  RSTA, RSTB, RSTC, RSTD, RSTM, RSTP, RSTCARRYIN, RSTOPMODE,
`ifdef DSP48A1_ZERO_DETECT_EN
      output PZERO,
`endif
      output M, P, PCOUT, CARRYOUT, CARRYOUTF, BCOUT
   );

endinterface

// File: rtl/dsp48a1_pipe_reg.sv
// One optional pipeline stage: CE hold, sync active-high clear, async active-low reset, or pass-through when EN=0.
module dsp48a1_pipe_reg #(
   parameter int W  = 18,
   parameter bit EN = 1'b1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         ce_i,
   input  logic         srst_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] q_q, q_d;

   always_comb begin
      q_d = q_q;
      if (srst_i)    q_d = '0;
      else if (ce_i) q_d = d_i;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) q_q <= '0;
      else        q_q <= q_d;
   end

   // Bypass keeps the flop in the source so every input is used; it is pruned in synthesis.
   assign q_o = EN ? q_q : d_i;

endmodule

// File: rtl/dsp48a1_slice.sv
// DSP48A1 slice: pre-adder, 18x18 unsigned multiplier, 48-bit post-adder, cascades; DSP48A1_ZERO_DETECT_EN adds PZERO.
module dsp48a1_slice
   import dsp48a1_pkg::*;
#(
   parameter int    A0REG       = 0,
   parameter int    A1REG       = 1,
   parameter int    B0REG       = 0,
   parameter int    B1REG       = 1,
   parameter int    CREG        = 1,
   parameter int    DREG        = 1,
   parameter int    MREG        = 1,
   parameter int    PREG        = 1,
   parameter int    CARRYINREG  = 1,
   parameter int    CARRYOUTREG = 1,
   parameter int    OPMODEREG   = 1,
   parameter string CARRYINSEL  = "OPMODE5",
   parameter string B_INPUT     = "DIRECT"
) (
   input logic           CLK,
   input logic           RST_N,
   dsp48a1_slice_if.slave bus
);

   localparam bit CIN_FROM_OP   = (CARRYINSEL == CINSEL_OPMODE5);
   localparam bit CIN_FROM_PORT = (CARRYINSEL == CINSEL_CARRYIN);
   localparam bit B_FROM_PORT   = (B_INPUT == BIN_DIRECT);
   localparam bit B_FROM_CASC   = (B_INPUT == BIN_CASCADE);

   logic [W_AB-1:0] b_src, a0, a1, b0, b1, d_s, pre;
   logic [W_P-1:0]  c_s, x_mux, z_mux, p_s;
   logic [W_M-1:0]  prod, m_s;
   logic [7:0]      op;
   logic            cin_src, cin, co_s;
   logic [W_P:0]    xc_ext, post;

   always_comb begin
      b_src = '0;
      if (B_FROM_PORT)      b_src = bus.B;
      else if (B_FROM_CASC) b_src = bus.BCIN;
   end

   dsp48a1_pipe_reg #(.W(8), .EN(OPMODEREG != 0)) u_opm (
      .clk(CLK), .rst_n(RST_N), .ce_i(bus.CEOPMODE), .srst_i(bus.RSTOPMODE), .d_i(bus.OPMODE), .q_o(op));
   dsp48a1_pipe_reg #(.W(W_AB), .EN(A0REG != 0)) u_a0 (
      .clk(CLK), .rst_n(RST_N), .ce_i(bus.CEA), .srst_i(bus.RSTA), .d_i(bus.A), .q_o(a0));
   dsp48a1_pipe_reg #(.W(W_AB), .EN(A1REG != 0)) u_a1 (
      .clk(CLK), .rst_n(RST_N), .ce_i(bus.CEA), .srst_i(bus.RSTA), .d_i(a0), .q_o(a1));
   dsp48a1_pipe_reg #(.W(W_AB), .EN(B0REG != 0)) u_b0 (
      .clk(CLK), .rst_n(RST_N), .ce_i(bus.CEB), .srst_i(bus.RSTB), .d_i(b_src), .q_o(b0));
   dsp48a1_pipe_reg #(.W(W_AB), .EN(DREG != 0)) u_d (
      .clk(CLK), .rst_n(RST_N), .ce_i(bus.CED), .srst_i(bus.RSTD), .d_i(bus.D), .q_o(d_s));
   dsp48a1_pipe_reg #(.W(W_P), .EN(CREG != 0)) u_c (
      .clk(CLK), .rst_n(RST_N), .ce_i(bus.CEC), .srst_i(bus.RSTC), .d_i(bus.C), .q_o(c_s));

   always_comb begin
      pre = b0;
      if (op[OP_PRE_EN]) pre = op[OP_PRE_SUB] ? (d_s - b0) : (d_s + b0);
   end

   dsp48a1_pipe_reg #(.W(W_AB), .EN(B1REG != 0)) u_b1 (
      .clk(CLK), .rst_n(RST_N), .ce_i(bus.CEB), .srst_i(bus.RSTB), .d_i(pre), .q_o(b1));

   assign prod = W_M'(a1) * W_M'(b1);

   dsp48a1_pipe_reg #(.W(W_M), .EN(MREG != 0)) u_m (
      .clk(CLK), .rst_n(RST_N), .ce_i(bus.CEM), .srst_i(bus.RSTM), .d_i(prod), .q_o(m_s));

   always_comb begin
      cin_src = 1'b0;
      if (CIN_FROM_OP)        cin_src = op[OP_CIN];
      else if (CIN_FROM_PORT) cin_src = bus.CARRYIN;
   end

   dsp48a1_pipe_reg #(.W(1), .EN(CARRYINREG != 0)) u_cin (
      .clk(CLK), .rst_n(RST_N), .ce_i(bus.CECARRYIN), .srst_i(bus.RSTCARRYIN), .d_i(cin_src), .q_o(cin));

   always_comb begin
      x_mux = '0;
      case (x_sel_e'(op[OP_X_LSB +: 2]))
         X_M:     x_mux = W_P'(m_s);
         X_P:     x_mux = p_s;
         X_CAT:   x_mux = {d_s[11:0], a1, b1};
         default: x_mux = '0;
      endcase
   end

   always_comb begin
      z_mux = '0;
      case (z_sel_e'(op[OP_Z_LSB +: 2]))
         Z_PCIN:  z_mux = bus.PCIN;
         Z_P:     z_mux = p_s;
         Z_C:     z_mux = c_s;
         default: z_mux = '0;
      endcase
   end

   // 49-bit arithmetic: bit 48 is the carry on add and the borrow on subtract.
   assign xc_ext = {1'b0, x_mux} + {{W_P{1'b0}}, cin};
   assign post   = op[OP_POST_SUB] ? ({1'b0, z_mux} - xc_ext) : ({1'b0, z_mux} + xc_ext);

   dsp48a1_pipe_reg #(.W(W_P), .EN(PREG != 0)) u_p (
      .clk(CLK), .rst_n(RST_N), .ce_i(bus.CEP), .srst_i(bus.RSTP), .d_i(post[W_P-1:0]), .q_o(p_s));
   dsp48a1_pipe_reg #(.W(1), .EN(CARRYOUTREG != 0)) u_co (
      .clk(CLK), .rst_n(RST_N), .ce_i(bus.CECARRYIN), .srst_i(bus.RSTCARRYIN), .d_i(post[W_P]), .q_o(co_s));

`ifdef DSP48A1_ZERO_DETECT_EN
   logic pzero_s;
   dsp48a1_pipe_reg #(.W(1), .EN(PREG != 0)) u_pz (
      .clk(CLK), .rst_n(RST_N), .ce_i(bus.CEP), .srst_i(bus.RSTP),
      .d_i(post[W_P-1:0] == '0), .q_o(pzero_s));
   assign bus.PZERO = pzero_s;
`endif

   assign bus.M         = m_s;
   assign bus.P         = p_s;
   assign bus.PCOUT     = p_s;
   assign bus.CARRYOUT  = co_s;
   assign bus.CARRYOUTF = co_s;
   assign bus.BCOUT     = b1;

endmodule

// File: tb/tb_dsp48a1_slice.sv
// Directed bench for dsp48a1_slice (default parameters); PZERO is also checked when DSP48A1_ZERO_DETECT_EN is set.
module tb_dsp48a1_slice;

   logic CLK = 1'b0;
   logic RST_N;
   int   n_checks = 0;
   int   n_fail   = 0;

   dsp48a1_slice_if bus ();

   dsp48a1_slice dut (.CLK(CLK), .RST_N(RST_N), .bus(bus));

   always #5 CLK = ~CLK;

   task automatic check_val(input string tag, input logic [47:0] obs, input logic [47:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic set_ce(input logic v);
      bus.CEA = v; bus.CEB = v; bus.CEC = v; bus.CED = v;
      bus.CEM = v; bus.CEP = v; bus.CECARRYIN = v; bus.CEOPMODE = v;
   endtask

   task automatic set_rst(input logic v);
      bus.RSTA = v; bus.RSTB = v; bus.RSTC = v; bus.RSTD = v;
      bus.RSTM = v; bus.RSTP = v; bus.RSTCARRYIN = v; bus.RSTOPMODE = v;
   endtask

   task automatic randomize_data();
      bus.A = 18'($urandom); bus.B = 18'($urandom); bus.D = 18'($urandom);
      bus.BCIN = 18'($urandom); bus.C = {16'($urandom), 32'($urandom)};
      bus.PCIN = {16'($urandom), 32'($urandom)}; bus.OPMODE = 8'($urandom);
      bus.CARRYIN = 1'($urandom);
   endtask

   task automatic check_outs(input string tag, input logic [47:0] bc, input logic [47:0] m,
                             input logic [47:0] p, input logic co);
      check_val({tag, ".BCOUT"},     48'(bus.BCOUT), bc);
      check_val({tag, ".M"},         48'(bus.M), m);
      check_val({tag, ".P"},         bus.P, p);
      check_val({tag, ".PCOUT"},     bus.PCOUT, p);
      check_val({tag, ".CARRYOUT"},  48'(bus.CARRYOUT), 48'(co));
      check_val({tag, ".CARRYOUTF"}, 48'(bus.CARRYOUTF), 48'(co));
   endtask

   initial begin
      RST_N = 1'b0;
      set_ce(1'b1);
      set_rst(1'b0);
      randomize_data();
      #12;
      check_outs("reset_n", 48'h0, 48'h0, 48'h0, 1'b0);
`ifdef DSP48A1_ZERO_DETECT_EN
      check_val("reset_n.PZERO", 48'(bus.PZERO), 48'h0);
`endif
      @(negedge CLK);
      RST_N = 1'b1;

      // Pre-subtract, post-subtract: C - A*(D-B)
      bus.A = 18'd20; bus.B = 18'd10; bus.D = 18'd25; bus.C = 48'd350;
      bus.PCIN = 48'd0; bus.BCIN = 18'd0; bus.CARRYIN = 1'b0;
      bus.OPMODE = 8'b1101_1101;
      tick(4);
      check_outs("presub", 48'hF, 48'h12C, 48'h32, 1'b0);

      bus.OPMODE = 8'b0001_0000;
      tick(3);
      check_outs("preadd", 48'h23, 48'h2BC, 48'h0, 1'b0);
`ifdef DSP48A1_ZERO_DETECT_EN
      check_val("preadd.PZERO", 48'(bus.PZERO), 48'h1);
`endif

      bus.OPMODE = 8'b0000_1010;
      tick(3);
      check_outs("feedback", 48'hA, 48'hC8, 48'h0, 1'b0);

      // PCIN - ({D[11:0],A1,B1} + 1)
      bus.A = 18'd5; bus.B = 18'd6; bus.D = 18'd25; bus.PCIN = 48'd3000;
      bus.OPMODE = 8'b1010_0111;
      tick(3);
      check_outs("concat_sub", 48'h6, 48'h1E, 48'hFE6F_FFEC_0BB1, 1'b1);

      set_ce(1'b0);
      for (int i = 0; i < 3; i++) begin
         randomize_data();
         tick(1);
         check_outs($sformatf("hold%0d", i), 48'h6, 48'h1E, 48'hFE6F_FFEC_0BB1, 1'b1);
      end

      bus.RSTP = 1'b1;
      tick(1);
      bus.RSTP = 1'b0;
      check_outs("rstp", 48'h6, 48'h1E, 48'h0, 1'b1);

      // All sync resets together must win over whatever the CEs are doing.
      set_rst(1'b1);
      bus.CEA = 1'($urandom); bus.CEB = 1'($urandom); bus.CEM = 1'($urandom);
      bus.CEP = 1'($urandom); bus.CECARRYIN = 1'($urandom); bus.CEOPMODE = 1'($urandom);
      randomize_data();
      tick(1);
      set_rst(1'b0);
      check_outs("sync_rst", 48'h0, 48'h0, 48'h0, 1'b0);

      // Load C into P, then double via P+P feedback on each enabled cycle.
      set_ce(1'b1);
      bus.A = 18'd0; bus.B = 18'd0; bus.D = 18'd0; bus.C = 48'd7;
      bus.OPMODE = 8'b0000_1100;
      tick(3);
      check_val("load_c.P", bus.P, 48'd7);
      bus.OPMODE = 8'b0000_1010;
      tick(3);
      check_val("accum.P", bus.P, 48'd28);
      bus.CEP = 1'b0;
      tick(2);
      check_val("accum_hold.P", bus.P, 48'd28);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
